// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared definitions for the display BCD scheduler: digit width,
//               FSM state encoding, the saturated all-9s digit pattern and the
//               leading-zero blanking helper.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int DIGIT_W    = 4;
    // Upper bound on displayed digits supported by the shared helpers.
    localparam int DIGITS_MAX = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [DIGIT_W*DIGITS_MAX-1:0] SAT_BCD = {DIGITS_MAX{4'h9}};

    // Bit i (i >= 1) is set when digits i..n_digits-1 are all zero, so the
    // display shows no leading zeros. Digit 0 is never blanked, which keeps a
    // single "0" visible for a zero value. Bits at or above n_digits are 0.
    function automatic logic [DIGITS_MAX-1:0] blank_mask_of(
        input logic [DIGIT_W*DIGITS_MAX-1:0] word,
        input int                            n_digits
    );
        logic [DIGITS_MAX-1:0] mask;
        logic                  lead;
        logic                  unused_d0;
        mask      = '0;
        lead      = 1'b1;
        unused_d0 = |word[DIGIT_W-1:0];
        for (int i = DIGITS_MAX - 1; i >= 1; i--) begin
            if (i < n_digits) begin
                lead    = lead & (word[DIGIT_W*i +: DIGIT_W] == '0);
                mask[i] = lead;
            end
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_bcd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : display_bcd_scheduler_if
// Description : Request/result bundle between a value source and the BCD
//               scheduler.
//               value, load, auto_en : request side (driven by master)
//               busy, done, bcd, blank_mask, overflow : result side (slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface display_bcd_scheduler_if #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
);
    logic [BIN_W-1:0]    value;
    logic                load;
    logic                auto_en;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank_mask;
    logic                overflow;

    modport master (
        output value, load, auto_en,
        input  busy, done, bcd, blank_mask, overflow
    );

    modport slave (
        input  value, load, auto_en,
        output busy, done, bcd, blank_mask, overflow
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble digit correction: adds 3 to a BCD digit that is
//               5 or more so the following left shift carries correctly.
//               din  : 4-bit digit before correction
//               dout : 4-bit digit after correction
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;
endmodule
`default_nettype wire

// File: rtl/display_bcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_bcd_scheduler
// Description : Converts a binary value to packed BCD with an iterative
//               double-dabble engine and publishes digits, leading-zero mask
//               and overflow for a seven-segment display bank. Conversions
//               are started by a load pulse or a periodic refresh tick; a
//               one-deep pending flag absorbs requests made while busy.
//               clock, reset_n : clock and asynchronous active-low reset
//               bus (slave)    : value/load/auto_en in;
//                                busy/done/bcd/blank_mask/overflow out
// Revision    : 1.0 - initial release
// ============================================================================
module display_bcd_scheduler
    import display_pkg::*;
#(
    parameter int BIN_W       = 20,
    parameter int DIGITS      = 6,
    parameter int REFRESH_DIV = 5000000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    display_bcd_scheduler_if.slave bus
);

    localparam int SCR_W  = DIGIT_W * (DIGITS + 1);
    localparam int BCD_W  = DIGIT_W * DIGITS;
    localparam int ITER_W = $clog2(BIN_W + 1);
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam logic [DIGITS-1:0] MASK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t                 state;
    state_t                 state_next;
    logic                   start;

    logic [CNT_W-1:0]       tick_cnt;
    logic                   tick;
    logic                   trigger;
    logic                   pending;

    logic [BIN_W-1:0]       shreg;
    logic [SCR_W-1:0]       scratch;
    logic [SCR_W-1:0]       scratch_adj;
    logic [ITER_W-1:0]      iter;

    logic                   busy_q;
    logic                   done_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [DIGITS-1:0]      mask_q;
    logic                   overflow_q;

    logic [DIGIT_W*DIGITS_MAX-1:0] word_pad;
    logic [DIGITS_MAX-1:0]  mask_full;
    logic                   overflow_next;
    logic [BCD_W-1:0]       bcd_next;
    logic [DIGITS-1:0]      mask_next;

    // ---------------- refresh tick ----------------
    assign tick    = bus.auto_en && (tick_cnt == CNT_W'(REFRESH_DIV - 1));
    assign trigger = bus.load | tick;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (!bus.auto_en || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (trigger || pending) begin
                    state_next = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (iter == ITER_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- double-dabble datapath ----------------
    // The extra top digit only catches values beyond the displayable range.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[DIGIT_W*g +: DIGIT_W]),
            .dout (scratch_adj[DIGIT_W*g +: DIGIT_W])
        );
    end

    always_comb begin
        word_pad              = '0;
        word_pad[BCD_W-1:0]   = scratch[BCD_W-1:0];
    end

    assign mask_full     = blank_mask_of(word_pad, DIGITS);
    assign overflow_next = |scratch[SCR_W-1 -: DIGIT_W];
    assign bcd_next      = overflow_next ? SAT_BCD[BCD_W-1:0] : scratch[BCD_W-1:0];
    assign mask_next     = overflow_next ? '0 : mask_full[DIGITS-1:0];

    if (DIGITS < DIGITS_MAX) begin : g_mask_hi
        logic unused_mask_hi;
        assign unused_mask_hi = |mask_full[DIGITS_MAX-1:DIGITS];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            scratch    <= '0;
            iter       <= '0;
            pending    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            mask_q     <= MASK_RST;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bus.value;
                        scratch <= '0;
                        iter    <= ITER_W'(BIN_W);
                        pending <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= {scratch_adj, shreg} << 1;
                    iter             <= iter - ITER_W'(1);
                    if (trigger) pending <= 1'b1;
                end
                DONE: begin
                    bcd_q      <= bcd_next;
                    mask_q     <= mask_next;
                    overflow_q <= overflow_next;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    if (trigger) pending <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.bcd        = bcd_q;
    assign bus.blank_mask = mask_q;
    assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_display_bcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_bcd_scheduler
// Description : Directed self-checking bench for display_bcd_scheduler with a
//               short refresh period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_bcd_scheduler;

    localparam int BIN_W       = 20;
    localparam int DIGITS      = 6;
    localparam int REFRESH_DIV = 30;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    display_bcd_scheduler_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    display_bcd_scheduler #(
        .BIN_W       (BIN_W),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the load is sampled at the following posedge and
    // the task returns at the negedge after that edge.
    task automatic pulse_load(input logic [BIN_W-1:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
    endtask

    // n counts negedges since the start edge (1 = first negedge after it).
    task automatic wait_done(output int n);
        n = 1;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
    endtask

    // Counts negedges from now until done is seen.
    task automatic wait_done_from_now(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.done !== 1'b1 && n < 200);
    endtask

    task automatic convert(input string tag, input logic [BIN_W-1:0] v,
                           input logic [23:0] exp_bcd, input logic [5:0] exp_mask,
                           input logic exp_ovf);
        int n;
        pulse_load(v);
        check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        check({tag, "_latency"},  32'(n), 32'd22);
        check({tag, "_bcd"},      32'(bus.bcd), 32'(exp_bcd));
        check({tag, "_mask"},     32'(bus.blank_mask), 32'(exp_mask));
        check({tag, "_ovf"},      32'(bus.overflow), 32'(exp_ovf));
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        @(negedge clock);
        check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n;
        int cnt;
        bus.value   = '0;
        bus.load    = 1'b0;
        bus.auto_en = 1'b0;

        // ---- reset values ----
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd",  32'(bus.bcd), 32'h0);
        check("rst_mask", 32'(bus.blank_mask), 32'b111110);
        check("rst_ovf",  32'(bus.overflow), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_no_conv", 32'(bus.busy), 32'd0);

        // ---- basic conversions ----
        convert("v123456", 20'd123456,  24'h123456, 6'b000000, 1'b0);
        convert("v42",     20'd42,      24'h000042, 6'b111100, 1'b0);
        convert("v0",      20'd0,       24'h000000, 6'b111110, 1'b0);
        convert("v1000000",20'd1000000, 24'h999999, 6'b000000, 1'b1);
        convert("v999999", 20'd999999,  24'h999999, 6'b000000, 1'b0);
        convert("v1048575",20'd1048575, 24'h999999, 6'b000000, 1'b1);

        // ---- load mid-conversion with value change ----
        pulse_load(20'd55);
        repeat (4) @(negedge clock);
        bus.value = 20'd7;
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
        wait_done(n);
        check("mid_first_bcd", 32'(bus.bcd), 32'h000055);
        @(negedge clock);
        check("mid_restart_busy", 32'(bus.busy), 32'd1);
        check("mid_stable_bcd",   32'(bus.bcd), 32'h000055);
        wait_done(n);
        check("mid_second_lat", 32'(n), 32'd22);
        check("mid_second_bcd", 32'(bus.bcd), 32'h000007);
        check("mid_second_mask", 32'(bus.blank_mask), 32'b111110);

        // ---- several loads while busy collapse into one ----
        pulse_load(20'd3);
        bus.value = 20'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.load = 1'b1;
            @(negedge clock);
            bus.load = 1'b0;
        end
        wait_done(n);
        check("multi_first_bcd", 32'(bus.bcd), 32'h000003);
        @(negedge clock);
        check("multi_restart_busy", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("multi_second_bcd", 32'(bus.bcd), 32'h000008);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        check("multi_no_third", 32'(cnt), 32'd0);

        // ---- periodic refresh ----
        bus.value   = 20'd250;
        bus.auto_en = 1'b1;
        wait_done_from_now(n);
        check("auto_first_lat", 32'(n), 32'd51);
        check("auto_bcd",  32'(bus.bcd), 32'h000250);
        check("auto_mask", 32'(bus.blank_mask), 32'b111000);
        wait_done_from_now(n);
        check("auto_period1", 32'(n), 32'd30);
        wait_done_from_now(n);
        check("auto_period2", 32'(n), 32'd30);
        bus.auto_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        check("auto_off_quiet", 32'(cnt), 32'd0);
        bus.auto_en = 1'b1;
        wait_done_from_now(n);
        check("auto_reenable_lat", 32'(n), 32'd51);
        bus.auto_en = 1'b0;
        @(negedge clock);

        // ---- asynchronous reset mid-conversion ----
        pulse_load(20'd123456);
        repeat (9) @(negedge clock);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_bcd",  32'(bus.bcd), 32'h0);
        check("arst_mask", 32'(bus.blank_mask), 32'b111110);
        check("arst_ovf",  32'(bus.overflow), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        check("post_rst_idle", 32'(cnt), 32'd0);
        check("post_rst_bcd",  32'(bus.bcd), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_bcd_scheduler.md
Name: display_bcd_scheduler

Overview:
- Sequences updates of the 6-digit seven-segment display bank.
- Converts a binary value (e.g. DDS output frequency) to packed BCD using an iterative shift-add-3 (double-dabble) engine, then presents the result as the 24-bit digit word for the display controller.
- Updates are triggered by an explicit load pulse or by an internal refresh tick, so displayed digits change at a readable rate.
- A one-deep pending flag absorbs requests that arrive mid-conversion.

Parameters:
- BIN_W, 20, width of binary input (max 1048575).
- DIGITS, 6, number of displayed BCD digits.
- REFRESH_DIV, 5000000, clock cycles between auto-refresh ticks (10 Hz at 50 MHz); minimum 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- value  in  BIN_W  binary value to display; sampled only at conversion start.
- load  in  1  single-cycle update request.
- auto_en  in  1  enables periodic refresh tick.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when outputs update.
- bcd  out  4*DIGITS  packed BCD, digit i at [4i+3:4i]; drives display controller num.
- blank_mask  out  DIGITS  bit i=1 when digit i is a leading zero.
- overflow  out  1  last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - state=IDLE, busy=0, done=0, bcd=0, overflow=0, pending=0, tick counter=0.
  - blank_mask={DIGITS-1{1},0}, which displays "0".
- Tick counter:
  - Counts 0..REFRESH_DIV-1 only while auto_en=1; held at 0 while auto_en=0.
  - At terminal count it raises tick for one cycle and wraps to 0.
- trigger = load | tick. Simultaneous load and tick form a single trigger.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge where trigger=1 or pending=1: capture value into the shift register, clear the (DIGITS+1)-digit scratch, set iter=BIN_W, clear pending, go to SHIFT, busy=1.
- SHIFT, one iteration per edge:
  - Every scratch digit >=5 gets +3.
  - Then shift {scratch, shreg} left by 1.
  - iter decrements; leave for DONE after exactly BIN_W iterations.
- DONE, on one edge:
  - Register outputs: bcd, overflow, blank_mask.
  - Assert done=1 for the following cycle; busy=0; go to IDLE.
- Output rules:
  - overflow=1 when the extra top scratch digit is non-zero; bcd is then saturated to all 9s (24'h999999).
  - Otherwise bcd holds the low DIGITS scratch digits.
  - blank_mask bit i (i>=1) = 1 iff digits i..DIGITS-1 are all 0. Bit 0 is always 0. When overflow=1, blank_mask=0.
- Latency: trigger sampled at edge k -> bcd/done valid after edge k+BIN_W+1 (22 edges for BIN_W=20). busy is high from edge k to edge k+BIN_W+1.
- Trigger while busy: sets pending. Multiple triggers collapse into one.
- Back-to-back conversion: with pending=1 on return to IDLE, the next conversion starts on the first IDLE edge with value re-sampled there, so done-to-next-busy is 1 cycle.
- Input stability: value changes during a conversion have no effect on it.
- auto_en deasserted mid-conversion: the conversion completes; pending is unaffected.
- Reset mid-conversion: conversion aborted; all outputs return to reset values immediately.
- bcd, blank_mask and overflow change only at the DONE edge and are stable otherwise.

Decomposition:
- Shared package display_pkg:
  - DIGIT_W=4.
  - FSM state encoding (IDLE/SHIFT/DONE).
  - SAT_BCD constant (all-9s pattern).
  - Helper function computing blank_mask from a packed BCD word.
- One natural sub-module, bcd_digit_adj: combinational 4-bit "+3 if >=5" correction, instantiated DIGITS+1 times in a generate loop.

Test Plan:
- value=123456, load pulse, auto_en=0 -> busy for 22 edges; done pulse; bcd=24'h123456, blank_mask=6'b000000, overflow=0.
- value=42 load, then value=0 load -> first bcd=24'h000042 with mask=6'b111100; second bcd=24'h000000 with mask=6'b111110.
- value=1000000 load -> overflow=1, bcd=24'h999999, mask=0. Then value=999999 -> overflow=0, bcd=24'h999999.
- load at cycle 5 of a running conversion, with value changed to 7 -> first result unchanged; second conversion starts 1 cycle after done; final bcd=24'h000007. Three extra loads produce only one extra conversion.
- REFRESH_DIV=30, auto_en=1, value=250 -> done pulses every 30 cycles with bcd=24'h000250. Deasserting auto_en stops ticks and clears the counter.
- reset_n low at iteration 10 -> busy, done and bcd return to reset values asynchronously. After release, no conversion runs without a new trigger.
